// File: rtl/uart_tx_periph_if.sv
// ---------------------------------------------------------------------------
// uart_tx_periph_if
//   Bus bundle between the SoC bus decoder/CPU side and the UART TX responder.
//   master : drives address, write data, select, write strobe and access size;
//            samples read data.
//   slave  : the peripheral side; returns combinational read data.
//   Handshake: a write commits on the rising clk edge where bSel & bWrite are
//   both high; a read is bSel high with bWrite low and bRData is valid in the
//   same cycle (zero wait states, no ready signal).
// ---------------------------------------------------------------------------
interface uart_tx_periph_if;
   logic [31:0] bAddr;
   logic [31:0] bWData;
   logic        bSel;
   logic        bWrite;
   logic [1:0]  mem_size;
   logic [31:0] bRData;

   modport master (
      output bAddr, bWData, bSel, bWrite, mem_size,
      input  bRData
   );

   modport slave (
      input  bAddr, bWData, bSel, bWrite, mem_size,
      output bRData
   );
endinterface

// File: rtl/uart_tx_periph.sv
// ---------------------------------------------------------------------------
// uart_tx_periph
//   Memory-mapped 8N1 UART transmitter with a TX FIFO and a drain interrupt.
//   Ports:
//     clk        system clock, all state on the rising edge
//     rst        asynchronous active-low reset
//     bus        bus responder (uart_tx_periph_if.slave)
//     txOut      serial output, idle high
//     txIrq      level interrupt: IRQEN & FIFO empty & transmitter idle
//     dbg_state  current transmit FSM state (IDLE=0 START=1 DATA=2 STOP=3)
//   Register map (bAddr[3:2]):
//     0 TXDATA   W: push bWData[7:0]          R: 0
//     1 STATUS   R: [0]full [1]empty [2]busy [3]overflow [11:8]count
//                W: writing 1 to bit 3 clears overflow
//     2 BAUDDIV  R/W [15:0], bit period = BAUDDIV+1 clocks
//     3 CTRL     R/W [0]EN [1]IRQEN
// ---------------------------------------------------------------------------
module uart_tx_periph #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd433
) (
   input  logic                   clk,
   input  logic                   rst,
   uart_tx_periph_if.slave        bus,
   output logic                   txOut,
   output logic                   txIrq,
   output logic [1:0]             dbg_state
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t        state_q, state_d;

   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;

   logic [15:0]   baud_div;
   logic          ctrl_en, ctrl_irqen;

   logic [7:0]    shift_q;
   logic [2:0]    bit_cnt;
   logic [15:0]   div_cnt, div_reload;

   logic [1:0]    reg_sel;
   logic          wr_en, push_req, push_ok, pop;
   logic          full, empty, busy, tick;

   // Address/data bits the register map does not decode.
   logic          unused_bits;
   assign unused_bits = ^{bus.bAddr[31:4], bus.bAddr[1:0], bus.bWData[31:16], bus.mem_size};

   assign reg_sel  = bus.bAddr[3:2];
   assign wr_en    = bus.bSel & bus.bWrite;
   assign push_req = wr_en & (reg_sel == 2'd0);
   assign full     = (count == CW'(FIFO_DEPTH));
   assign empty    = (count == '0);
   // A push into a full FIFO still lands when the FSM pops on the same edge.
   assign push_ok  = push_req & (~full | pop);
   assign busy     = (state_q != S_IDLE);
   assign tick     = (div_cnt == 16'd0);

   // ---------------- transmit FSM: state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // ---------------- transmit FSM: next state / pop ----------------
   // pop only looks at the registered count, so a byte pushed this cycle
   // into an empty FIFO is popped on the following edge at the earliest.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ctrl_en && !empty) begin
               pop     = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick) state_d = S_DATA;
         end
         S_DATA: begin
            if (tick && bit_cnt == 3'd7) state_d = S_STOP;
         end
         S_STOP: begin
            if (tick) begin
               if (ctrl_en && !empty) begin
                  pop     = 1'b1;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      case (state_q)
         S_START: txOut = 1'b0;
         S_DATA:  txOut = shift_q[0];
         default: txOut = 1'b1;
      endcase
   end

   assign txIrq     = ctrl_irqen & empty & ~busy;
   assign dbg_state = state_q;

   // ---------------- shifter and bit-period divider ----------------
   // BAUDDIV is captured into div_reload only when a frame starts, so a
   // mid-frame BAUDDIV write takes effect on the next frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q    <= 8'd0;
         bit_cnt    <= 3'd0;
         div_cnt    <= 16'd0;
         div_reload <= 16'd0;
      end else if (pop) begin
         shift_q    <= fifo_mem[rd_ptr];
         div_reload <= baud_div;
         div_cnt    <= baud_div;
         bit_cnt    <= 3'd0;
      end else if (busy) begin
         if (tick) begin
            div_cnt <= div_reload;
            if (state_q == S_DATA) begin
               shift_q <= {1'b0, shift_q[7:1]};
               bit_cnt <= bit_cnt + 3'd1;
            end
         end else begin
            div_cnt <= div_cnt - 16'd1;
         end
      end
   end

   // ---------------- FIFO ----------------
   // When full, a push and a pop on the same edge address the same slot;
   // the pop reads the old byte before the push overwrites it.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= bus.bWData[7:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (push_req && full && !pop)
            overflow <= 1'b1;
         else if (wr_en && reg_sel == 2'd1 && bus.bWData[3])
            overflow <= 1'b0;
      end
   end

   // ---------------- control registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         baud_div   <= DIV_RESET;
         ctrl_en    <= 1'b0;
         ctrl_irqen <= 1'b0;
      end else if (wr_en) begin
         case (reg_sel)
            2'd2: baud_div <= bus.bWData[15:0];
            2'd3: begin
               ctrl_en    <= bus.bWData[0];
               ctrl_irqen <= bus.bWData[1];
            end
            default: ;
         endcase
      end
   end

   // ---------------- read mux ----------------
   // count sits from bit 8 upward (fits [11:8] for the default depth).
   always_comb begin
      bus.bRData = 32'h0;
      if (bus.bSel) begin
         case (reg_sel)
            2'd1:    bus.bRData = (32'(count) << 8) | {28'd0, overflow, busy, empty, full};
            2'd2:    bus.bRData = {16'd0, baud_div};
            2'd3:    bus.bRData = {30'd0, ctrl_irqen, ctrl_en};
            default: bus.bRData = 32'h0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_periph.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_periph
//   Directed + randomized bench for uart_tx_periph. The reference model is a
//   byte queue of what software pushed plus a sticky overflow flag; expected
//   serial waveforms are built from each byte as {stop, data, start} with each
//   bit held BAUDDIV+1 clocks.
// ---------------------------------------------------------------------------
module tb_uart_tx_periph;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tx_out, tx_irq;
   logic [1:0] dbg_state;

   uart_tx_periph_if bus();

   uart_tx_periph #(.FIFO_DEPTH(DEPTH), .DIV_RESET(16'd433)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .txOut     (tx_out),
      .txIrq     (tx_irq),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard / model state ----------------
   logic [7:0] exp_q[$];
   logic       m_ovf;
   int         total;
   int         bad;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_status(input bit busy);
      int n = exp_q.size();
      return (32'(n) << 8) | {28'd0, m_ovf, busy, (n == 0), (n == DEPTH)};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic bus_write(input logic [1:0] sel, input logic [31:0] data);
      logic [31:0] a;
      a          = $urandom();
      a[3:2]     = sel;
      bus.bAddr  = a;
      bus.bWData = data;
      bus.mem_size = 2'($urandom_range(0, 2));
      bus.bSel   = 1'b1;
      bus.bWrite = 1'b1;
      @(posedge clk);
      #1;
      bus.bSel   = 1'b0;
      bus.bWrite = 1'b0;
      case (sel)
         2'd0: if (exp_q.size() < DEPTH) exp_q.push_back(data[7:0]); else m_ovf = 1'b1;
         2'd1: if (data[3]) m_ovf = 1'b0;
         default: ;
      endcase
   endtask

   task automatic bus_read(input logic [1:0] sel, output logic [31:0] data);
      logic [31:0] a;
      a          = $urandom();
      a[3:2]     = sel;
      bus.bAddr  = a;
      bus.bSel   = 1'b1;
      bus.bWrite = 1'b0;
      #1;
      data       = bus.bRData;
      bus.bSel   = 1'b0;
   endtask

   task automatic chk_reg(input string tag, input logic [1:0] sel, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(sel, d);
      chk(tag, d, exp);
   endtask

   // Call with the next negedge being the first START cycle.
   task automatic check_frame(input string tag, input int baud);
      logic [7:0] b;
      logic [9:0] frame;
      b     = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      frame = {1'b1, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c <= baud; c++) begin
            @(negedge clk);
            chk($sformatf("%s_bit%0d", tag, i), 32'(tx_out), 32'(frame[i]));
         end
      end
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] b;
      int         baud;
      int         n;

      total = 0;
      bad   = 0;
      m_ovf = 1'b0;
      bus.bAddr    = '0;
      bus.bWData   = '0;
      bus.bSel     = 1'b0;
      bus.bWrite   = 1'b0;
      bus.mem_size = 2'd0;

      // Reset values
      #1;
      chk("rst_txout", 32'(tx_out), 32'd1);
      chk("rst_irq", 32'(tx_irq), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reg("t1_status", 2'd1, 32'h0000_0002);
      chk_reg("t1_baud", 2'd2, 32'd433);
      chk_reg("t1_ctrl", 2'd3, 32'd0);
      chk_reg("t1_txdata_rd", 2'd0, 32'd0);
      bus.bAddr = 32'h4;
      #1;
      chk("t1_nosel_rdata", bus.bRData, 32'd0);
      chk("t1_txout", 32'(tx_out), 32'd1);
      chk("t1_irq", 32'(tx_irq), 32'd0);

      // Single frame 0xA5 at 4 clk/bit
      bus_write(2'd2, 32'd3);
      bus_write(2'd3, 32'd1);
      bus_write(2'd0, 32'h1234_56A5);
      @(posedge clk); #1;
      check_frame("t2", 3);
      @(posedge clk); #1;
      chk_reg("t2_idle_status", 2'd1, exp_status(1'b0));

      // Overflow, clear, back-to-back drain, push into full FIFO during pop
      bus_write(2'd3, 32'd0);
      baud = $urandom_range(0, 3);
      bus_write(2'd2, 32'(baud));
      for (int i = 0; i < 9; i++) bus_write(2'd0, $urandom());
      chk_reg("t3_full_ovf", 2'd1, exp_status(1'b0));
      bus_write(2'd1, 32'h8);
      chk_reg("t3_ovf_clr", 2'd1, exp_status(1'b0));
      bus_write(2'd3, 32'd1);
      @(posedge clk); #1;
      fork
         begin
            for (int f = 0; f < 10; f++) check_frame($sformatf("t3_f%0d", f), baud);
         end
         begin
            bus_write(2'd0, $urandom());
            chk_reg("t3_refull", 2'd1, exp_status(1'b1));
            repeat (10 * (baud + 1) - 2) @(posedge clk);
            #1;
            bus_write(2'd0, $urandom());
            chk_reg("t3_push_at_pop", 2'd1, exp_status(1'b1));
         end
      join
      @(posedge clk); #1;
      chk_reg("t3_drained", 2'd1, exp_status(1'b0));

      // Interrupt behaviour at 1 clk/bit
      bus_write(2'd2, 32'd0);
      bus_write(2'd3, 32'd3);
      chk("t4_irq_idle", 32'(tx_irq), 32'd1);
      bus_write(2'd0, 32'h0);
      chk("t4_irq_fall", 32'(tx_irq), 32'd0);
      @(posedge clk); #1;
      check_frame("t4_f0", 0);
      chk("t4_irq_in_stop", 32'(tx_irq), 32'd0);
      @(posedge clk); #1;
      chk("t4_irq_rise", 32'(tx_irq), 32'd1);
      bus_write(2'd0, $urandom());
      chk("t4_irq_fall2", 32'(tx_irq), 32'd0);
      @(posedge clk); #1;
      check_frame("t4_f1", 0);
      @(posedge clk); #1;
      chk("t4_irq_rise2", 32'(tx_irq), 32'd1);

      // Mid-frame BAUDDIV change and EN clear
      bus_write(2'd3, 32'd0);
      bus_write(2'd2, 32'd3);
      bus_write(2'd3, 32'd1);
      bus_write(2'd0, $urandom());
      bus_write(2'd0, $urandom());
      fork
         check_frame("t5_f0", 3);
         begin
            repeat (8) @(posedge clk);
            #1;
            bus_write(2'd2, 32'd7);
            bus_write(2'd3, 32'd0);
         end
      join
      repeat (20) begin
         @(negedge clk);
         chk("t5_hold_idle", 32'(tx_out), 32'd1);
      end
      chk_reg("t5_queued", 2'd1, exp_status(1'b0));
      bus_write(2'd3, 32'd1);
      @(posedge clk); #1;
      check_frame("t5_f1", 7);
      @(posedge clk); #1;
      chk_reg("t5_done", 2'd1, exp_status(1'b0));

      // Randomized bursts
      for (int r = 0; r < 3; r++) begin
         bus_write(2'd3, 32'd0);
         baud = $urandom_range(0, 2);
         bus_write(2'd2, 32'(baud));
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) bus_write(2'd0, $urandom());
         chk_reg($sformatf("rnd%0d_status", r), 2'd1, exp_status(1'b0));
         bus_write(2'd3, 32'd1);
         @(posedge clk); #1;
         for (int f = 0; f < n; f++) check_frame($sformatf("rnd%0d_f%0d", r, f), baud);
         @(posedge clk); #1;
         chk_reg($sformatf("rnd%0d_drained", r), 2'd1, exp_status(1'b0));
      end

      // Reset during DATA bit 4
      bus_write(2'd3, 32'd0);
      bus_write(2'd2, 32'd3);
      b = 8'($urandom()) & 8'hEF;
      bus_write(2'd0, {24'd0, b});
      bus_write(2'd0, $urandom());
      bus_write(2'd0, $urandom());
      bus_write(2'd3, 32'd1);
      @(posedge clk); #1;
      repeat (21) @(negedge clk);
      chk("t6_bit4_low", 32'(tx_out), 32'd0);
      #1;
      rst = 1'b0;
      #1;
      chk("t6_txout_rst", 32'(tx_out), 32'd1);
      chk("t6_irq_rst", 32'(tx_irq), 32'd0);
      exp_q.delete();
      m_ovf = 1'b0;
      chk_reg("t6_status_in_rst", 2'd1, exp_status(1'b0));
      @(negedge clk);
      rst = 1'b1;
      chk_reg("t6_status", 2'd1, 32'h0000_0002);
      chk_reg("t6_baud", 2'd2, 32'd433);
      chk_reg("t6_ctrl", 2'd3, 32'd0);
      repeat (40) begin
         @(negedge clk);
         chk("t6_no_residual", 32'(tx_out), 32'd1);
      end
      bus_write(2'd3, 32'd1);
      repeat (20) begin
         @(negedge clk);
         chk("t6_empty_idle", 32'(tx_out), 32'd1);
      end
      chk_reg("t6_final_status", 2'd1, exp_status(1'b0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
